// File: rtl/lsu_mem_ctrl_if.sv
// Core-side request/response bus and memory-side request/data bus of the
// load/store controller, bundled so the controller takes a single port.
interface lsu_mem_ctrl_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [2:0]  load_type;
  logic [1:0]  store_type;
  logic        cpu_busy;
  logic        cpu_done;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  logic        cpu_misalign;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  // slave: the controller; master: the core and memory that surround it
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, load_type, store_type,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output cpu_busy, cpu_done, cpu_rdata, cpu_err, cpu_misalign,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, load_type, store_type,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  cpu_busy, cpu_done, cpu_rdata, cpu_err, cpu_misalign,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory controller: aligns core accesses onto a 32-bit
// request/grant/rvalid memory bus with misalignment and timeout aborts.
module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic           clk,
  input logic           rst_n,
  lsu_mem_ctrl_if.slave bus
);
  localparam int unsigned   CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [2:0]    ltype_q, ltype_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          mis_q, mis_d;

  logic        is_lb, is_lh, is_lw, st_b, st_h, st_w, misaligned, timeout;
  logic [3:0]  be_new;
  logic [31:0] wdata_new, load_data;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    is_lb = (bus.load_type == 3'b001) || (bus.load_type == 3'b011);
    is_lh = (bus.load_type == 3'b010) || (bus.load_type == 3'b100);
    is_lw = !is_lb && !is_lh;
    st_b  = (bus.store_type == 2'b01);
    st_h  = (bus.store_type == 2'b10);
    st_w  = !st_b && !st_h;
    if (bus.cpu_we) begin
      misaligned = (st_w && (bus.cpu_addr[1:0] != 2'b00)) || (st_h && bus.cpu_addr[0]);
      if (st_b) begin
        be_new    = 4'b0001 << bus.cpu_addr[1:0];
        wdata_new = {4{bus.cpu_wdata[7:0]}};
      end else if (st_h) begin
        be_new    = 4'b0011 << bus.cpu_addr[1:0];
        wdata_new = {2{bus.cpu_wdata[15:0]}};
      end else begin
        be_new    = 4'b1111;
        wdata_new = bus.cpu_wdata;
      end
    end else begin
      misaligned = (is_lw && (bus.cpu_addr[1:0] != 2'b00)) || (is_lh && bus.cpu_addr[0]);
      be_new     = 4'b1111;
      wdata_new  = '0;
    end
  end

  always_comb begin
    case (addr_q[1:0])
      2'd0:    lane_b = bus.mem_rdata[7:0];
      2'd1:    lane_b = bus.mem_rdata[15:8];
      2'd2:    lane_b = bus.mem_rdata[23:16];
      default: lane_b = bus.mem_rdata[31:24];
    endcase
    lane_h = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (ltype_q)
      3'b001:  load_data = {{24{lane_b[7]}}, lane_b};
      3'b011:  load_data = {24'd0, lane_b};
      3'b010:  load_data = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_data = {16'd0, lane_h};
      default: load_data = bus.mem_rdata;
    endcase
  end

  // gnt/rvalid are tested before the timeout so a response on the last
  // permitted cycle completes normally.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    ltype_d = ltype_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    mis_d   = 1'b0;
    timeout = (cnt_q >= CNT_LAST);
    case (state_q)
      S_IDLE: begin
        if (bus.cpu_req) begin
          we_d    = bus.cpu_we;
          addr_d  = bus.cpu_addr;
          ltype_d = bus.load_type;
          be_d    = be_new;
          wdata_d = wdata_new;
          cnt_d   = '0;
          if (misaligned) begin
            state_d = S_RESP;
            mis_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (bus.mem_gnt) begin
          cnt_d = cnt_q + 1'b1;
          if (we_q) begin
            state_d = S_RESP;
            rdata_d = '0;
          end else begin
            state_d = S_WAIT;
          end
        end else if (timeout) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (bus.mem_rvalid) begin
          state_d = S_RESP;
          rdata_d = load_data;
        end else if (timeout) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    mem_req_d = (state_d == S_REQ);
    mem_we_d  = (state_d == S_REQ) && we_d;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      ltype_q   <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      ltype_q   <= ltype_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      mis_q     <= mis_d;
    end
  end

  assign bus.cpu_busy     = busy_q;
  assign bus.cpu_done     = done_q;
  assign bus.cpu_rdata    = rdata_q;
  assign bus.cpu_err      = err_q;
  assign bus.cpu_misalign = mis_q;
  assign bus.mem_req      = mem_req_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = {addr_q[31:2], 2'b00};
  assign bus.mem_be       = be_q;
  assign bus.mem_wdata    = wdata_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: a driver issues accesses and plays the
// memory, a monitor scores every cpu_done against a queue of expectations.
module tb_lsu_mem_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  lsu_mem_ctrl_if bus ();

  lsu_mem_ctrl #(.TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        mis;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every completion pulse consumes one expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (prev_done) chk("done_one_cycle", {31'd0, bus.cpu_done}, 32'd0);
      if (bus.cpu_done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got cpu_done=1 expected no completion (t=%0t)", $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("cpu_rdata", bus.cpu_rdata, mon_e.rdata);
          chk("cpu_err", {31'd0, bus.cpu_err}, {31'd0, mon_e.err});
          chk("cpu_misalign", {31'd0, bus.cpu_misalign}, {31'd0, mon_e.mis});
          chk("latency", cyc - mon_e.acc, mon_e.lat);
        end
      end
    end
    prev_done = bus.cpu_done;
  end

  task automatic wait_idle();
    int n = 0;
    while (bus.cpu_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.cpu_busy) begin
      checks++;
      errors++;
      $display("FAIL idle_wait: got cpu_busy=1 expected 0 within 50 cycles");
    end
  endtask

  task automatic check_req(input logic we, input logic [31:0] addr,
                           input logic [3:0] xbe, input logic [31:0] xwd);
    logic [31:0] waddr;
    waddr = {addr[31:2], 2'b00};
    chk("req_mem_req", {31'd0, bus.mem_req}, 32'd1);
    chk("req_busy", {31'd0, bus.cpu_busy}, 32'd1);
    chk("req_mem_we", {31'd0, bus.mem_we}, {31'd0, we});
    chk("req_mem_addr", bus.mem_addr, waddr);
    chk("req_mem_be", {28'd0, bus.mem_be}, {28'd0, xbe});
    if (we) chk("req_mem_wdata", bus.mem_wdata, xwd);
  endtask

  // gd/rd: cycles before gnt / rvalid; 255 means never.
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] lt, input logic [1:0] st, input int gd, input int rd,
                           input logic [31:0] mrd, input logic [31:0] xrd, input logic xerr,
                           input logic xmis, input logic [3:0] xbe, input logic [31:0] xwd,
                           input int xlat);
    exp_t e;
    int   n;
    wait_idle();
    bus.cpu_req    = 1'b1;
    bus.cpu_we     = we;
    bus.cpu_addr   = addr;
    bus.cpu_wdata  = wdata;
    bus.load_type  = lt;
    bus.store_type = st;
    e.rdata = xrd;
    e.err   = xerr;
    e.mis   = xmis;
    e.lat   = xlat;
    e.acc   = cyc;
    exp_q.push_back(e);
    @(negedge clk);
    bus.cpu_req    = 1'b0;
    bus.cpu_we     = ~we;
    bus.cpu_addr   = 32'hFFFF_FFFF;
    bus.cpu_wdata  = 32'hFFFF_FFFF;
    bus.load_type  = 3'b111;
    bus.store_type = 2'b11;
    if (xmis) begin
      n = 0;
      while (bus.cpu_busy && n < 8) begin
        chk("mis_no_mem_req", {31'd0, bus.mem_req}, 32'd0);
        @(negedge clk);
        n++;
      end
    end else begin
      n = 0;
      while (n < gd && bus.mem_req && n < 40) begin
        check_req(we, addr, xbe, xwd);
        @(negedge clk);
        n++;
      end
      if (bus.mem_req) begin
        check_req(we, addr, xbe, xwd);
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        if (!we) begin
          chk("wait_mem_req", {31'd0, bus.mem_req}, 32'd0);
          n = 0;
          while (n < rd && bus.cpu_busy && !bus.cpu_done && n < 40) begin
            @(negedge clk);
            n++;
          end
          if (bus.cpu_busy && !bus.cpu_done) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = mrd;
            @(negedge clk);
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = '0;
          end
        end
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_cpu_busy"}, {31'd0, bus.cpu_busy}, 32'd0);
    chk({tag, "_cpu_done"}, {31'd0, bus.cpu_done}, 32'd0);
    chk({tag, "_cpu_rdata"}, bus.cpu_rdata, 32'd0);
    chk({tag, "_cpu_err"}, {31'd0, bus.cpu_err}, 32'd0);
    chk({tag, "_cpu_misalign"}, {31'd0, bus.cpu_misalign}, 32'd0);
    chk({tag, "_mem_req"}, {31'd0, bus.mem_req}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, bus.mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
    chk({tag, "_mem_be"}, {28'd0, bus.mem_be}, 32'd0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got no finish expected finish before 20000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b1;
    bus.cpu_req    = 1'b0;
    bus.cpu_we     = 1'b0;
    bus.cpu_addr   = '0;
    bus.cpu_wdata  = '0;
    bus.load_type  = '0;
    bus.store_type = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    #1 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //        we    addr          wdata         lt      st     gd   rd   mem_rdata     exp_rdata     err   mis   be       wdata         lat
    do_access(1'b0, 32'h0000_0103, 32'h0,        3'b001, 2'b00, 0,   0,   32'h80FF_1234, 32'hFFFF_FF80, 1'b0, 1'b0, 4'b1111, 32'h0,        3);
    do_access(1'b0, 32'h0000_0102, 32'h0,        3'b100, 2'b00, 0,   0,   32'h8001_0000, 32'h0000_8001, 1'b0, 1'b0, 4'b1111, 32'h0,        3);
    do_access(1'b0, 32'h0000_0102, 32'h0,        3'b010, 2'b00, 0,   0,   32'h8001_0000, 32'hFFFF_8001, 1'b0, 1'b0, 4'b1111, 32'h0,        3);
    do_access(1'b1, 32'h0000_0202, 32'h0000_ABCD, 3'b000, 2'b10, 3,   0,   32'h0,        32'h0,        1'b0, 1'b0, 4'b1100, 32'hABCD_ABCD, 5);
    do_access(1'b0, 32'h0000_0101, 32'h0,        3'b000, 2'b00, 0,   0,   32'h0,        32'h0,        1'b0, 1'b1, 4'b0000, 32'h0,        1);
    do_access(1'b1, 32'h0000_0301, 32'h1234_5678, 3'b000, 2'b01, 0,   0,   32'h0,        32'h0,        1'b0, 1'b0, 4'b0010, 32'h7878_7878, 2);
    do_access(1'b1, 32'h0000_0400, 32'hDEAD_BEEF, 3'b000, 2'b11, 0,   0,   32'h0,        32'h0,        1'b0, 1'b0, 4'b1111, 32'hDEAD_BEEF, 2);
    do_access(1'b0, 32'h0000_0501, 32'h0,        3'b011, 2'b00, 0,   0,   32'h1122_8344, 32'h0000_0083, 1'b0, 1'b0, 4'b1111, 32'h0,        3);
    do_access(1'b0, 32'h0000_0600, 32'h0,        3'b000, 2'b00, 1,   2,   32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 1'b0, 4'b1111, 32'h0,        6);
    do_access(1'b0, 32'h0000_0604, 32'h0,        3'b111, 2'b00, 0,   0,   32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 4'b1111, 32'h0,        3);
    do_access(1'b0, 32'h0000_0602, 32'h0,        3'b111, 2'b00, 0,   0,   32'h0,        32'h0,        1'b0, 1'b1, 4'b0000, 32'h0,        1);
    do_access(1'b1, 32'h0000_0201, 32'h0000_1111, 3'b000, 2'b10, 0,   0,   32'h0,        32'h0,        1'b0, 1'b1, 4'b0000, 32'h0,        1);
    do_access(1'b0, 32'h0000_0103, 32'h0,        3'b010, 2'b00, 0,   0,   32'h0,        32'h0,        1'b0, 1'b1, 4'b0000, 32'h0,        1);
    do_access(1'b1, 32'h0000_0003, 32'h0000_00AB, 3'b000, 2'b01, 0,   0,   32'h0,        32'h0,        1'b0, 1'b0, 4'b1000, 32'hABAB_ABAB, 2);
    do_access(1'b0, 32'h0000_0700, 32'h0,        3'b010, 2'b00, 0,   14,  32'h0000_7F80, 32'h0000_7F80, 1'b0, 1'b0, 4'b1111, 32'h0,        17);
    do_access(1'b0, 32'h0000_0800, 32'h0,        3'b000, 2'b00, 15,  0,   32'h55AA_55AA, 32'h55AA_55AA, 1'b0, 1'b0, 4'b1111, 32'h0,        18);
    do_access(1'b1, 32'h0000_0A00, 32'h0BAD_F00D, 3'b000, 2'b00, 255, 0,   32'h0,        32'h0,        1'b1, 1'b0, 4'b1111, 32'h0BAD_F00D, 17);
    do_access(1'b0, 32'h0000_0B00, 32'h0,        3'b000, 2'b00, 0,   255, 32'h0,        32'h0,        1'b1, 1'b0, 4'b1111, 32'h0,        17);

    // late rvalid/gnt while idle must not start or complete anything
    wait_idle();
    bus.mem_rvalid = 1'b1;
    bus.mem_gnt    = 1'b1;
    bus.mem_rdata  = 32'h1234_5678;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ignore_busy", {31'd0, bus.cpu_busy}, 32'd0);
      chk("idle_ignore_mem_req", {31'd0, bus.mem_req}, 32'd0);
    end
    bus.mem_rvalid = 1'b0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rdata  = '0;

    // reset asserted mid-access while waiting for read data
    @(negedge clk);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 32'h0000_0900;
    bus.load_type = 3'b000;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    chk("midwait_busy", {31'd0, bus.cpu_busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midwait_reset");
    @(negedge clk);
    rst_n = 1'b1;

    do_access(1'b0, 32'h0000_0900, 32'h0,        3'b001, 2'b00, 0,   0,   32'h0000_007F, 32'h0000_007F, 1'b0, 1'b0, 4'b1111, 32'h0,        3);

    wait_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
